// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI-RAM command arbiter.
// Opcodes match the RAM's two-word command protocol.
package spi_ram_pkg;

  localparam int DW = 8;
  localparam int AW = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_DATA,
    RD_WAIT,
    DONE
  } state_e;

  function automatic logic [AW+1:0] mk_cmd(
    input logic [1:0]    op,
    input logic [AW-1:0] pl
  );
    return {op, pl};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// Pointer resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (en_i && (|req_i)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Shares a single-port SPI-slave RAM between two requesters,
// issuing two-word commands and returning read data.
module ram_cmd_arbiter
  import spi_ram_pkg::*;
#(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic [9:0]    ram_din,
  output logic          ram_rx_valid,
  input  logic [DW-1:0] ram_dout,
  input  logic          ram_tx_valid
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_e        state_q;
  logic          owner_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [1:0]    ack_q;
  logic [DW-1:0] rdata_q;
  logic [9:0]    din_q;
  logic          rxv_q;

  logic [1:0]    gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    own_ack;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt)
  );

  assign sel_we    = gnt[0] ? we[0]  : we[1];
  assign sel_addr  = gnt[0] ? addr0  : addr1;
  assign sel_wdata = gnt[0] ? wdata0 : wdata1;
  assign own_ack   = owner_q ? 2'b10 : 2'b01;

  // Command outputs are loaded on entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      din_q   <= '0;
      rxv_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      din_q <= '0;
      rxv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q <= gnt[1];
            wdata_q <= sel_wdata;
            rxv_q   <= 1'b1;
            if (sel_we) begin
              din_q   <= mk_cmd(OP_WR_ADDR, sel_addr);
              state_q <= WR_ADDR;
            end else begin
              din_q   <= mk_cmd(OP_RD_ADDR, sel_addr);
              state_q <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          din_q   <= mk_cmd(OP_WR_DATA, wdata_q);
          rxv_q   <= 1'b1;
          state_q <= WR_DATA;
        end
        WR_DATA: begin
          ack_q   <= own_ack;
          state_q <= DONE;
        end
        RD_ADDR: begin
          din_q   <= mk_cmd(OP_RD_DATA, '0);
          rxv_q   <= 1'b1;
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          cnt_q   <= '0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (ram_tx_valid) begin
            rdata_q <= ram_dout;
            ack_q   <= own_ack;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            ack_q   <= own_ack;
            state_q <= DONE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign err          = err_q;
  assign busy         = (state_q != IDLE);
  assign ram_din      = din_q;
  assign ram_rx_valid = rxv_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Scoreboard bench for ram_cmd_arbiter with a behavioural
// RAM model and a transaction-level reference model.
module tb_ram_cmd_arbiter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, we, ack;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [7:0] rdata, ram_dout;
  logic       err, busy, ram_rx_valid, ram_tx_valid;
  logic [9:0] ram_din;

  ram_cmd_arbiter #(.TIMEOUT_CYC(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .ack          (ack),
    .rdata        (rdata),
    .err          (err),
    .busy         (busy),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit abort  = 0;

  typedef struct {
    logic [9:0] w;
    int         c;
  } cmd_t;

  typedef struct {
    logic [1:0] a;
    logic       e;
    logic [7:0] d;
    int         c;
  } ack_t;

  cmd_t cmdq[$];
  ack_t ackq[$];

  // reference model state
  logic [7:0] ref_mem [256];
  bit         last;
  logic [7:0] last_rd;

  // per-requester scenario knobs
  int p_delay [2];
  bit p_never [2];
  bit p_stray [2];
  bit p_mut   [2];

  // RAM model knobs for the transaction in flight
  int         rd_delay;
  bit         rd_never;
  bit         stray_en;
  logic [7:0] ram_mem [256];

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // RAM model: decodes command words, answers reads after rd_delay
  initial begin : ram_model
    int         pend;
    logic [7:0] wa, ra, rsp;
    pend = 0; wa = 0; ra = 0; rsp = 0;
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h00;
    forever begin
      @(posedge clk); #1;
      ram_tx_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ram_tx_valid = 1'b1;
          ram_dout     = rsp;
        end
      end
      @(negedge clk);
      if (ram_rx_valid && !rst) begin
        case (ram_din[9:8])
          2'b00: begin
            wa = ram_din[7:0];
            if (stray_en) begin
              pend = 1;
              rsp  = 8'($urandom);
            end
          end
          2'b01: ram_mem[wa] = ram_din[7:0];
          2'b10: ra = ram_din[7:0];
          default: begin
            if (!rd_never) begin
              pend = rd_delay + 1;
              rsp  = ram_mem[ra];
            end
          end
        endcase
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents output
  initial begin : monitor
    cmd_t ce;
    ack_t ae;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ram_rx_valid) begin
          if (cmdq.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_cmd: got %0h at cycle %0d",
                     ram_din, cyc);
          end else begin
            ce = cmdq.pop_front();
            check("cmd_word", 32'(ram_din), 32'(ce.w));
            check("cmd_cycle", cyc, ce.c);
          end
        end else begin
          check("idle_din", 32'(ram_din), 32'h0);
        end
        if (ack != 2'b00) begin
          if (ackq.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_ack: got %0b at cycle %0d",
                     ack, cyc);
          end else begin
            ae = ackq.pop_front();
            check("ack_owner", 32'(ack), 32'(ae.a));
            check("ack_err", 32'(err), 32'(ae.e));
            check("ack_rdata", 32'(rdata), 32'(ae.d));
            check("ack_cycle", cyc, ae.c);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    last = 1'b1;
    last_rd = 8'h00;
  endtask

  // Runs grants until req drops; must start in an IDLE cycle.
  task automatic serve(input logic [1:0] rq, input bit hold,
                       input int ngr);
    int         c0, w, lim, cexp, got;
    logic [7:0] a, d;
    logic       wr;
    req = rq;
    c0  = cyc;
    got = 0;
    while (req != 2'b00 && !abort) begin
      if (req == 2'b11) w = last ? 0 : 1;
      else              w = req[1] ? 1 : 0;
      last = (w == 1);
      a  = (w == 1) ? addr1  : addr0;
      d  = (w == 1) ? wdata1 : wdata0;
      wr = we[w];
      rd_delay = p_delay[w];
      rd_never = p_never[w];
      stray_en = p_stray[w];
      if (wr) begin
        cmdq.push_back('{{2'b00, a}, c0 + 1});
        cmdq.push_back('{{2'b01, d}, c0 + 2});
        ref_mem[a] = d;
        cexp = c0 + 3;
        ackq.push_back('{(w == 1) ? 2'b10 : 2'b01, 1'b0,
                         last_rd, cexp});
      end else begin
        cmdq.push_back('{{2'b10, a}, c0 + 1});
        cmdq.push_back('{{2'b11, 8'h00}, c0 + 2});
        if (p_never[w]) begin
          cexp    = c0 + 3 + T;
          last_rd = 8'h00;
          ackq.push_back('{(w == 1) ? 2'b10 : 2'b01, 1'b1,
                           8'h00, cexp});
        end else begin
          cexp    = c0 + 4 + p_delay[w];
          last_rd = ref_mem[a];
          ackq.push_back('{(w == 1) ? 2'b10 : 2'b01, 1'b0,
                           last_rd, cexp});
        end
      end
      lim = cexp + 4;
      tick();
      if (p_mut[w]) begin
        if (w == 1) begin
          addr1  = 8'($urandom);
          wdata1 = 8'($urandom);
        end else begin
          addr0  = 8'($urandom);
          wdata0 = 8'($urandom);
        end
        we[w] = ~we[w];
      end
      while (ack == 2'b00 && cyc < lim) tick();
      if (ack == 2'b00) begin
        checks++; errors++;
        $display("FAIL ack_timeout: no ack by cycle %0d", lim);
        abort = 1;
      end else begin
        got++;
        if (!hold)         req[w] = 1'b0;
        else if (got == ngr) req  = 2'b00;
        tick();
        c0 = cyc;
      end
    end
  endtask

  task automatic clr_knobs();
    for (int i = 0; i < 2; i++) begin
      p_delay[i] = 0;
      p_never[i] = 0;
      p_stray[i] = 0;
      p_mut[i]   = 0;
    end
  endtask

  initial begin : driver
    int c0;
    rst = 1'b1;
    req = 2'b00; we = 2'b00;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    rd_delay = 0; rd_never = 0; stray_en = 0;
    last = 1'b1; last_rd = 8'h00;
    clr_knobs();
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i) ^ 8'h5A;
      ram_mem[i] = 8'(i) ^ 8'h5A;
    end
    repeat (3) tick();
    check("rst_ack", 32'(ack), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_din", 32'(ram_din), 0);
    check("rst_rxv", 32'(ram_rx_valid), 0);
    rst = 1'b0;
    tick();

    // directed write then read-back of the same address
    we = 2'b01; addr0 = 8'h3C; wdata0 = 8'hA5;
    serve(2'b01, 0, 0);
    we = 2'b00; addr1 = 8'h3C;
    serve(2'b10, 0, 0);

    // timeout read, then a normal read
    p_never[0] = 1; addr0 = 8'h11;
    serve(2'b01, 0, 0);
    clr_knobs();
    p_delay[0] = 2;
    serve(2'b01, 0, 0);

    // stray tx_valid during a write, fields changed after grant
    clr_knobs();
    p_stray[0] = 1; p_mut[0] = 1;
    we = 2'b01; addr0 = 8'h77; wdata0 = 8'h5E;
    serve(2'b01, 0, 0);
    clr_knobs();

    // both requesting writes continuously from reset
    we = 2'b11;
    addr0 = 8'h01; wdata0 = 8'hC0;
    addr1 = 8'h02; wdata1 = 8'hC1;
    do_reset();
    serve(2'b11, 1, 4);

    // randomized transactions
    for (int n = 0; n < 60 && !abort; n++) begin
      we     = 2'($urandom);
      addr0  = 8'($urandom_range(0, 15));
      addr1  = 8'($urandom_range(0, 15));
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        p_delay[i] = $urandom_range(0, T - 1);
        p_never[i] = ($urandom_range(0, 5) == 0);
        p_stray[i] = ($urandom_range(0, 3) == 0);
        p_mut[i]   = ($urandom_range(0, 3) == 0);
      end
      serve(2'($urandom_range(1, 3)),
            $urandom_range(0, 3) == 0, 3);
      repeat ($urandom_range(0, 2)) tick();
    end
    clr_knobs();

    // reset while a read waits for RAM data
    if (!abort) begin
      p_never[1] = 1; rd_never = 1; stray_en = 0;
      we = 2'b00; addr1 = 8'h42;
      req = 2'b10;
      c0  = cyc;
      cmdq.push_back('{{2'b10, 8'h42}, c0 + 1});
      cmdq.push_back('{{2'b11, 8'h00}, c0 + 2});
      while (cyc < c0 + 4) tick();
      rst = 1'b1;
      req = 2'b00;
      tick();
      check("midrst_busy", 32'(busy), 0);
      check("midrst_ack", 32'(ack), 0);
      check("midrst_rxv", 32'(ram_rx_valid), 0);
      check("midrst_din", 32'(ram_din), 0);
      rst = 1'b0;
      last = 1'b1; last_rd = 8'h00;
      clr_knobs();
      tick();
      we = 2'b10; addr1 = 8'h9A; wdata1 = 8'h3D;
      serve(2'b10, 0, 0);
      we = 2'b00; addr0 = 8'h9A;
      serve(2'b01, 0, 0);
    end

    repeat (3) tick();
    check("cmdq_left", cmdq.size(), 0);
    check("ackq_left", ackq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
